// File: rtl/spongent_round_ctrl.sv
// ----------------------------------------------------------------------------
// spongent_round_ctrl
//
// Iterative Spongent permutation engine. Each round is one CNT cycle, which
// XORs the round-counter LFSR into both ends of the state, followed by NB SP
// cycles. Each SP cycle pushes one state byte through the S-box layer and
// scatters the eight result bits to their pLayer destinations in next_q.
// The last SP cycle of a round commits next_q, including the bits written in
// that same cycle, back into the state register.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      permutation request, sampled only while idle
//   state_in   B-bit input state, captured on the accepting edge
//   busy       high while a permutation is running
//   done       one-cycle pulse on completion
//   state_out  B-bit result, held until the next run completes
//
// Parameters
//   B        state width in bits (multiple of 8)
//   R        number of rounds
//   LC_INIT  round-counter LFSR seed
//   SBOX_ID  1 replaces the S-box with identity (pLayer characterisation)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; state_out holds the last result
// CNT   | XOR round counter into the state, step the LFSR
// SP    | S-box + pLayer scatter of byte byte_q; commit on last byte
// ----------------------------------------------------------------------------
module spongent_round_ctrl #(
  parameter int         B       = 88,
  parameter int         R       = 45,
  parameter logic [5:0] LC_INIT = 6'h05,
  parameter bit         SBOX_ID = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [B-1:0] state_in,
  output logic         busy,
  output logic         done,
  output logic [B-1:0] state_out
);

  localparam int NB  = B / 8;
  localparam int RW  = $clog2(R + 1);
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int DW  = $clog2(B);
  localparam int DW1 = DW + 1;

  // Destination arithmetic is done one bit wider than DW so that the sum
  // before the conditional subtract of (B-1) cannot overflow.
  localparam logic [DW1-1:0] LANE_STEP  = DW1'(B / 4);
  localparam logic [DW1-1:0] BYTE_STEP  = DW1'((2 * B) % (B - 1));
  localparam logic [DW1-1:0] MOD_V      = DW1'(B - 1);
  localparam logic [DW-1:0]  TOP_BIT    = DW'(B - 1);
  localparam logic [BW-1:0]  LAST_BYTE  = BW'(NB - 1);
  localparam logic [RW-1:0]  LAST_ROUND = RW'(R - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CNT  = 2'd1,
    SP   = 2'd2
  } fsm_e;

  fsm_e          fsm_q;
  logic [B-1:0]  state_q;
  logic [B-1:0]  next_q;
  logic [B-1:0]  out_q;
  logic [5:0]    lc_q;
  logic [RW-1:0] round_q;
  logic [BW-1:0] byte_q;
  logic [DW-1:0] d0_q;
  logic          busy_q;
  logic          done_q;

  logic [B-1:0]  cnt_d;
  logic [B-1:0]  merge_d;
  logic [5:0]    lc_d;
  logic [DW-1:0] d0_d;
  logic [7:0]    cur_byte;
  logic [7:0]    sub_byte;
  logic [DW-1:0] dest [8];
  logic [DW1-1:0] lane_acc;
  logic [DW1-1:0] base_acc;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hE;
      4'h1: y = 4'hD;
      4'h2: y = 4'hB;
      4'h3: y = 4'h0;
      4'h4: y = 4'h2;
      4'h5: y = 4'h1;
      4'h6: y = 4'h4;
      4'h7: y = 4'hF;
      4'h8: y = 4'h7;
      4'h9: y = 4'hA;
      4'hA: y = 4'h8;
      4'hB: y = 4'h5;
      4'hC: y = 4'h9;
      4'hD: y = 4'hC;
      4'hE: y = 4'h3;
      default: y = 4'h6;
    endcase
    return y;
  endfunction

  always_comb begin
    // Round-counter injection: lc at the bottom, bit-reversed lc at the top.
    cnt_d       = state_q;
    cnt_d[5:0]  = state_q[5:0] ^ lc_q;
    for (int i = 0; i < 6; i++) begin
      cnt_d[B-1-i] = state_q[B-1-i] ^ lc_q[i];
    end

    // x^6 + x^5 + 1, Fibonacci form, shifting left.
    lc_d = {lc_q[4:0], lc_q[5] ^ lc_q[4]};

    cur_byte = 8'(state_q >> {byte_q, 3'b000});
    if (SBOX_ID) begin
      sub_byte = cur_byte;
    end else begin
      sub_byte = {sbox(cur_byte[7:4]), sbox(cur_byte[3:0])};
    end

    // Lane t of byte k lands at P(8k) + t*B/4 mod (B-1). Each add is below
    // 2*(B-1), so one conditional subtract keeps the running value reduced.
    lane_acc = '0;
    dest[0]  = d0_q;
    for (int t = 1; t < 8; t++) begin
      lane_acc = {1'b0, dest[t-1]} + LANE_STEP;
      if (lane_acc >= MOD_V) begin
        lane_acc = lane_acc - MOD_V;
      end
      dest[t] = lane_acc[DW-1:0];
    end
    // Source bit B-1 is the fixed point of the pLayer.
    if (byte_q == LAST_BYTE) begin
      dest[7] = TOP_BIT;
    end

    merge_d = next_q;
    for (int t = 0; t < 8; t++) begin
      merge_d[dest[t]] = sub_byte[t];
    end

    // The base for the next byte advances by 8*B/4 mod (B-1).
    base_acc = {1'b0, d0_q} + BYTE_STEP;
    if (base_acc >= MOD_V) begin
      base_acc = base_acc - MOD_V;
    end
    d0_d = base_acc[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      next_q  <= '0;
      out_q   <= '0;
      lc_q    <= LC_INIT;
      round_q <= '0;
      byte_q  <= '0;
      d0_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (start) begin
            state_q <= state_in;
            lc_q    <= LC_INIT;
            round_q <= '0;
            byte_q  <= '0;
            d0_q    <= '0;
            busy_q  <= 1'b1;
            fsm_q   <= CNT;
          end
        end
        CNT: begin
          state_q <= cnt_d;
          lc_q    <= lc_d;
          fsm_q   <= SP;
        end
        SP: begin
          next_q <= merge_d;
          if (byte_q == LAST_BYTE) begin
            state_q <= merge_d;
            byte_q  <= '0;
            d0_q    <= '0;
            round_q <= round_q + 1'b1;
            if (round_q == LAST_ROUND) begin
              out_q  <= merge_d;
              done_q <= 1'b1;
              busy_q <= 1'b0;
              fsm_q  <= IDLE;
            end else begin
              fsm_q <= CNT;
            end
          end else begin
            byte_q <= byte_q + 1'b1;
            d0_q   <= d0_d;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign state_out = out_q;

endmodule

// File: doc/spongent_round_ctrl.md
SPONGENT_ROUND_CTRL -- requirements
Module: spongent_round_ctrl

Interface
REQ-001 SHALL have parameter B, default 88, meaning the state width in bits; it is a multiple of 8, with NB = B/8 bytes.
REQ-002 SHALL have parameter R, default 45, meaning the number of rounds.
REQ-003 SHALL have parameter LC_INIT, default 6'h05, meaning the round-counter LFSR seed.
REQ-004 SHALL have ports:
- clk  input  1  system clock; single clock domain, all flops on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a permutation; sampled only in IDLE.
- state_in  input  B  input state; captured on the accepting edge.
- busy  output  1  permutation in progress.
- done  output  1  one-cycle pulse marking completion.
- state_out  output  B  result; held stable until the next accepted start.

Function
REQ-005 SHALL use FSM states IDLE, CNT, SP.
- IDLE -> CNT on start=1.
- CNT -> SP unconditionally.
- SP -> CNT after byte NB-1 when the round is not the last.
- SP -> IDLE after byte NB-1 of round R-1.
REQ-006 SHALL ignore start outside IDLE; no queuing.
REQ-007 Accepting edge SHALL load state_reg<=state_in, lc<=LC_INIT, round<=0, byte<=0, and busy<=1.
REQ-008 CNT cycle:
- state_reg[5:0] ^= lc.
- state_reg[B-1:B-6] ^= bit-reverse(lc).
- lc advances one LFSR step: x^6+x^5+1, Fibonacci, shift left, new bit0 = lc[5]^lc[4].
REQ-009 SP cycle k (k = 0..NB-1):
- Read byte k of state_reg (bits 8k+7..8k).
- Apply the 4-bit S-box to each nibble. Table in hex, inputs 0..F: E D B 0 2 1 4 F 7 A 8 5 9 C 3 6.
- Scatter the 8 result bits into next_reg.
REQ-010 pLayer destination for source bit j SHALL be P(j) = (j*B/4) mod (B-1) for j < B-1, and P(B-1) = B-1.
REQ-011 Destinations SHALL be produced incrementally:
- Running base d0 = P(8k).
- Lane t is d0 + t*(B/4), reduced by conditional subtract of (B-1) per add step.
- Lane 7 of byte NB-1 is forced to B-1.
- No multiplier or divider.
REQ-012 next_reg SHALL be fully written over one SP pass; each destination bit is written exactly once per round (the permutation is a bijection).
REQ-013 On SP byte NB-1, state_reg SHALL take next_reg including that cycle's 8 bits (commit in the same cycle); round increments, byte returns to 0.
REQ-014 Latency SHALL be 1 + NB cycles per round. For defaults this is 12 per round, and the final commit is on edge 540 after the accepting edge.
REQ-015 On the final commit edge:
- state_out<=committed state.
- done<=1 for exactly one cycle.
- busy<=0.
REQ-016 A start asserted in the cycle done=1 SHALL be accepted (FSM is IDLE); state_out holds the prior result until that run's final commit.
REQ-017 state_out SHALL NOT change except on a final commit or reset.
REQ-018 round counter width SHALL be ceil(log2(R+1)); byte counter width ceil(log2(NB)); no wrap beyond R-1 or NB-1.

Reset
REQ-019 rst=0 SHALL asynchronously force:
- FSM to IDLE.
- busy=0, done=0.
- state_reg, next_reg, state_out to 0.
- lc to LC_INIT.
- round and byte counters to 0.
REQ-020 Reset mid-permutation SHALL abort with no done pulse; after release, the block accepts a new start normally.
REQ-021 Release of rst SHALL be treated as synchronous to clk by the integrator; the block adds no synchronizer.

Verification
REQ-022 Latency: defaults, start pulse with state_in=0 -> busy high for 540 cycles, done high exactly on cycle 541, state_out equal to the golden Spongent-88 permutation of 0.
REQ-023 pLayer: B=88, R=1, with an S-box-identity build option forced by bind in the bench, state_in = single bit j for each j in 0..87 -> state_out = 1<<P(j) XOR counter bits; 87->87, 1->22, 4->1.
REQ-024 LFSR: 63 consecutive rounds from LC_INIT=05 -> lc sequence period 63, no all-zero state, matching the golden model.
REQ-025 Busy ignore: start held high for the whole run with state_in changed mid-run -> result uses the first captured state only; a second run starts on the cycle after done.
REQ-026 Mid-run reset: rst=0 at cycle 200 -> all outputs 0 immediately, no done; restart yields the same result as REQ-022.
REQ-027 Back-to-back: start asserted during done -> second result valid 540 cycles later, state_out unchanged in between.
